mouse_crosshair_draw: RTL and testbench

//  Consumes the mouse position delivered in the 65 MHz pixel domain and

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_delay.sv | 41 ++++
 rtl/mouse_crosshair_draw.sv | 149 ++++++++++++++
 tb/tb_mouse_crosshair_draw.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: active area, cursor geometry, colours and the
// timing bus that travels alongside every pixel through the draw pipeline.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  localparam int ARM_LEN = 8;   // arm reach from centre, inclusive
  localparam int GAP     = 2;   // undrawn pixels next to the centre dot

  localparam logic [11:0] CROSS_COLOR = 12'hF00;
  localparam logic [11:0] CLICK_COLOR = 12'hFF0;

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - 1);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_bus;

  // Saturate a 12-bit mouse coordinate to the last visible pixel.
  function automatic logic [10:0] clamp_pos(input logic [11:0] pos,
                                            input logic [10:0] max_pos);
    return (pos > {1'b0, max_pos}) ? max_pos : pos[10:0];
  endfunction

  // Magnitude of a signed 13-bit distance; the result never exceeds 2047.
  function automatic logic [11:0] abs13(input logic signed [12:0] v);
    return v[12] ? 12'(-v) : 12'(v);
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth delay line for the VGA timing bus and its pixel colour, used to
// keep pass-through timing aligned with the draw pipeline.
module vga_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  vga_bus      bus_in,
  input  logic [11:0] rgb_in,
  output vga_bus      bus_out,
  output logic [11:0] rgb_out
);

  vga_bus      bus_pipe [DEPTH];
  logic [11:0] rgb_pipe [DEPTH];

  // Shift the bus and colour one stage per clock.
  // NOTE: every stage is cleared on reset because the outputs must read 0
  // while reset is held; a plain delay line could skip this reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bus_pipe[i] <= '0;
        rgb_pipe[i] <= '0;
      end
    end else begin
      bus_pipe[0] <= bus_in;
      rgb_pipe[0] <= rgb_in;
      for (int i = 1; i < DEPTH; i++) begin
        bus_pipe[i] <= bus_pipe[i-1];
        rgb_pipe[i] <= rgb_pipe[i-1];
      end
    end
  end

  assign bus_out = bus_pipe[DEPTH-1];
  assign rgb_out = rgb_pipe[DEPTH-1];

endmodule

// File: rtl/mouse_crosshair_draw.sv
// Crosshair cursor overlay. Mouse position and button are captured once per
// frame on the rising edge of vblnk, then a two-stage pipeline compares every
// pixel against the captured centre and replaces hits with the cursor colour.
module mouse_crosshair_draw
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic        mouse_left,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] GAP_W = 12'(GAP);
  localparam logic [11:0] ARM_W = 12'(ARM_LEN);

  // Frame-latched cursor state.
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic        cur_click;
  logic        vblnk_prev;
  logic        armed;        // set once vblnk has been seen low after reset
  logic        latch_en;

  // A vblnk that is already high when reset releases is not a new frame:
  // armed stays low until vblnk has been observed low at least once.
  assign latch_en = vblnk_in & ~vblnk_prev & armed;

  // Capture mouse position and button on the vblnk rising edge only.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x      <= 11'(H_ACTIVE / 2);
      cur_y      <= 11'(V_ACTIVE / 2);
      cur_click  <= 1'b0;
      vblnk_prev <= 1'b0;
      armed      <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      armed      <= armed | ~vblnk_in;
      if (latch_en) begin
        cur_x     <= clamp_pos(xpos_mouse, X_MAX);
        cur_y     <= clamp_pos(ypos_mouse, Y_MAX);
        cur_click <= mouse_left;
      end
    end
  end

  // Signed distances so arms clip at the border instead of wrapping.
  logic signed [12:0] dx;
  logic signed [12:0] dy;

  assign dx = $signed({2'b00, hcount_in}) - $signed({2'b00, cur_x});
  assign dy = $signed({2'b00, vcount_in}) - $signed({2'b00, cur_y});

  logic [11:0] adx_d1;
  logic [11:0] ady_d1;
  logic        dx_zero_d1;
  logic        dy_zero_d1;
  logic        visible_d1;
  logic        click_d1;

  // Stage 1: register distance magnitudes, blanking and the cursor colour
  // select that belongs to this pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      adx_d1     <= '0;
      ady_d1     <= '0;
      dx_zero_d1 <= 1'b0;
      dy_zero_d1 <= 1'b0;
      visible_d1 <= 1'b0;
      click_d1   <= 1'b0;
    end else begin
      adx_d1     <= abs13(dx);
      ady_d1     <= abs13(dy);
      dx_zero_d1 <= (dx == 13'sd0);
      dy_zero_d1 <= (dy == 13'sd0);
      visible_d1 <= ~hblnk_in & ~vblnk_in;
      click_d1   <= cur_click;
    end
  end

  logic hit;

  // Stage 2 hit test: horizontal arm, vertical arm or centre dot.
  // NOTE: hit gets a default before any condition so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    if (dy_zero_d1 && (adx_d1 > GAP_W) && (adx_d1 <= ARM_W)) hit = 1'b1;
    if (dx_zero_d1 && (ady_d1 > GAP_W) && (ady_d1 <= ARM_W)) hit = 1'b1;
    if (dx_zero_d1 && dy_zero_d1)                            hit = 1'b1;
  end

  logic        draw_d2;
  logic [11:0] color_d2;

  // Stage 2 register: draw decision and cursor colour for this pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_d2  <= 1'b0;
      color_d2 <= '0;
    end else begin
      draw_d2  <= hit & visible_d1;
      color_d2 <= click_d1 ? CLICK_COLOR : CROSS_COLOR;
    end
  end

  // Timing and background colour ride a two-deep delay line beside the
  // pipeline; the final mux sits directly on registered signals.
  vga_bus      bus_in;
  vga_bus      bus_d2;
  logic [11:0] rgb_d2;

  assign bus_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  vga_delay #(.DEPTH(2)) u_delay (
    .clk     (clk),
    .rst     (rst),
    .bus_in  (bus_in),
    .rgb_in  (rgb_in),
    .bus_out (bus_d2),
    .rgb_out (rgb_d2)
  );

  assign hcount_out = bus_d2.hcount;
  assign vcount_out = bus_d2.vcount;
  assign hsync_out  = bus_d2.hsync;
  assign vsync_out  = bus_d2.vsync;
  assign hblnk_out  = bus_d2.hblnk;
  assign vblnk_out  = bus_d2.vblnk;
  assign rgb_out    = draw_d2 ? color_d2 : rgb_d2;

endmodule

// File: tb/tb_mouse_crosshair_draw.sv
// Scoreboard bench for mouse_crosshair_draw: every driven cycle pushes the
// expected output; a negedge monitor pops and compares two cycles later.
module tb_mouse_crosshair_draw;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos_mouse, ypos_mouse;
  logic        mouse_left;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  mouse_crosshair_draw dut (
    .clk        (clk),
    .rst        (rst),
    .xpos_mouse (xpos_mouse),
    .ypos_mouse (ypos_mouse),
    .mouse_left (mouse_left),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: cursor as seen by the next displayed pixel.
  int m_cx    = H_ACTIVE / 2;
  int m_cy    = V_ACTIVE / 2;
  bit m_click = 1'b0;
  bit m_prev_vb = 1'b1;  // a high vblnk right after reset is not an edge

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (h,v,hs,vs,hb,vb,rgb)", name, act, req);
    end
  endtask

  function automatic exp_t zero_entry(input string tag);
    exp_t z;
    z.h = '0; z.v = '0; z.hs = 0; z.vs = 0; z.hb = 0; z.vb = 0; z.rgb = '0;
    z.tag = tag;
    return z;
  endfunction

  function automatic logic [11:0] model_pixel(input int h, input int v, input bit hb,
                                              input bit vb, input logic [11:0] rgb);
    int dx = h - m_cx;
    int dy = v - m_cy;
    int ax = (dx < 0) ? -dx : dx;
    int ay = (dy < 0) ? -dy : dy;
    bit on = (dx == 0 && dy == 0) ||
             (dy == 0 && ax > GAP && ax <= ARM_LEN) ||
             (dx == 0 && ay > GAP && ay <= ARM_LEN);
    if (on && !hb && !vb) return m_click ? CLICK_COLOR : CROSS_COLOR;
    return rgb;
  endfunction

  // One clock of stimulus; expected output recorded at the sampling edge.
  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hb,
                      input logic vb, input logic [11:0] rgb, input string tag,
                      input bit dir, input logic [11:0] dir_rgb);
    exp_t e;
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = vb & 1'($urandom_range(0, 1));
    e.h = h; e.v = v; e.hs = hsync_in; e.vs = vsync_in; e.hb = hb; e.vb = vb;
    e.tag = tag;
    e.rgb = dir ? dir_rgb : model_pixel(int'(h), int'(v), hb, vb, rgb);
    @(posedge clk);
    if (rst) begin
      // A reset edge also blanks the pixel issued one cycle earlier.
      if (sb.size() > 0) sb[sb.size()-1] = zero_entry(sb[sb.size()-1].tag);
      sb.push_back(zero_entry("reset"));
      m_cx = H_ACTIVE / 2; m_cy = V_ACTIVE / 2; m_click = 1'b0; m_prev_vb = 1'b1;
    end else begin
      sb.push_back(e);
      if (vb && !m_prev_vb) begin
        m_cx    = (xpos_mouse > 12'(H_ACTIVE - 1)) ? H_ACTIVE - 1 : int'(xpos_mouse);
        m_cy    = (ypos_mouse > 12'(V_ACTIVE - 1)) ? V_ACTIVE - 1 : int'(ypos_mouse);
        m_click = mouse_left;
      end
      m_prev_vb = vb;
    end
    #1;
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        step(11'(h), 11'(v), 1'b0, 1'b0, 12'($urandom), "scan", 1'b0, 12'h0);
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++)
      step(11'(i), 11'(V_ACTIVE + i), 1'b1, 1'b1, 12'($urandom), "vblank", 1'b0, 12'h0);
  endtask

  // Directed pixel with a hand-written expectation: 0 background, 1 cross, 2 click.
  task automatic dpix(input int h, input int v, input bit hb, input int kind, input string tag);
    logic [11:0] rgb;
    logic [11:0] req;
    rgb = 12'($urandom);
    if (rgb == CROSS_COLOR || rgb == CLICK_COLOR) rgb = 12'h123;
    req = (kind == 0) ? rgb : (kind == 1) ? CROSS_COLOR : CLICK_COLOR;
    step(11'(h), 11'(v), hb, 1'b0, rgb, tag, 1'b1, req);
  endtask

  // Monitor: an output is due once the entry behind it has also been issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        check(e.tag,
              {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out},
              {e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb});
      end
    end
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; xpos_mouse = '0; ypos_mouse = '0; mouse_left = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    for (int i = 0; i < 3; i++) step(11'd0, 11'd0, 1'b0, 1'b0, 12'hABC, "rst", 1'b0, 12'h0);
    rst = 1'b0;

    // 1: no vblnk edge yet, cursor sits at the centre
    xpos_mouse = 12'd50; ypos_mouse = 12'd60;
    scan(505, 520, 380, 388);
    dpix(512, 384, 1'b0, 1, "t1_centre");
    dpix(512, 384, 1'b1, 0, "t1_centre_hblnk");
    dpix(50, 60, 1'b0, 0, "t1_unlatched");

    // 2: latch centre explicitly, probe gap and arm ends
    xpos_mouse = 12'd512; ypos_mouse = 12'd384;
    vblank(4);
    dpix(515, 384, 1'b0, 1, "t2_h515");
    dpix(514, 384, 1'b0, 0, "t2_h514_gap");
    dpix(520, 384, 1'b0, 1, "t2_h520");
    dpix(521, 384, 1'b0, 0, "t2_h521");
    dpix(504, 384, 1'b0, 1, "t2_h504");
    dpix(503, 384, 1'b0, 0, "t2_h503");
    dpix(512, 387, 1'b0, 1, "t2_v387");
    dpix(512, 386, 1'b0, 0, "t2_v386_gap");
    dpix(512, 392, 1'b0, 1, "t2_v392");
    dpix(512, 393, 1'b0, 0, "t2_v393");
    dpix(513, 385, 1'b0, 0, "t2_diag");

    // 3: clamp to bottom-right corner, no wrap to column 0
    xpos_mouse = 12'd2000; ypos_mouse = 12'd900;
    vblank(4);
    for (int h = 1015; h <= 1020; h++) dpix(h, 767, 1'b0, 1, "t3_left_arm");
    dpix(1021, 767, 1'b0, 0, "t3_gap");
    dpix(1023, 767, 1'b0, 1, "t3_centre");
    dpix(1023, 759, 1'b0, 1, "t3_up_arm");
    dpix(1023, 758, 1'b0, 0, "t3_up_end");
    for (int h = 0; h <= 8; h++) dpix(h, 767, 1'b0, 0, "t3_no_wrap");
    scan(1010, 1023, 765, 767);

    // 3b: top-left corner, only right/down arms and centre
    xpos_mouse = 12'd0; ypos_mouse = 12'd0;
    vblank(4);
    dpix(0, 0, 1'b0, 1, "t3b_centre");
    dpix(2, 0, 1'b0, 0, "t3b_gap");
    dpix(3, 0, 1'b0, 1, "t3b_right");
    dpix(8, 0, 1'b0, 1, "t3b_right_end");
    dpix(9, 0, 1'b0, 0, "t3b_right_past");
    dpix(2045, 0, 1'b0, 0, "t3b_no_hwrap");
    dpix(0, 2044, 1'b0, 0, "t3b_no_vwrap");
    scan(0, 10, 0, 10);

    // 4: mid-frame position change waits for the next vblnk edge
    xpos_mouse = 12'd100; ypos_mouse = 12'd100;
    vblank(4);
    scan(90, 96, 100, 100);
    xpos_mouse = 12'd300;
    dpix(100, 100, 1'b0, 1, "t4_old_centre");
    dpix(104, 100, 1'b0, 1, "t4_old_arm");
    dpix(300, 100, 1'b0, 0, "t4_new_not_yet");
    vblank(4);
    dpix(300, 100, 1'b0, 1, "t4_new_centre");
    dpix(100, 100, 1'b0, 0, "t4_old_gone");

    // 5: click colour for the whole frame, release ignored until next edge
    xpos_mouse = 12'd200; ypos_mouse = 12'd150; mouse_left = 1'b1;
    vblank(4);
    dpix(200, 150, 1'b0, 2, "t5_click_centre");
    mouse_left = 1'b0;
    dpix(205, 150, 1'b0, 2, "t5_click_after_release");
    dpix(200, 158, 1'b0, 2, "t5_click_vert");
    scan(195, 205, 148, 152);
    vblank(4);
    dpix(200, 150, 1'b0, 1, "t5_released");

    // 6: reset mid-frame returns the cursor to centre
    xpos_mouse = 12'd640; ypos_mouse = 12'd480;
    scan(0, 5, 300, 300);
    rst = 1'b1;
    scan(6, 8, 300, 300);
    rst = 1'b0;
    scan(505, 520, 382, 386);
    dpix(512, 384, 1'b0, 1, "t6_centre");
    dpix(200, 150, 1'b0, 0, "t6_old_gone");
    dpix(640, 480, 1'b0, 0, "t6_no_latch");

    // 6b: vblnk high across reset release does not latch
    rst = 1'b1;
    vblank(2);
    rst = 1'b0;
    xpos_mouse = 12'd700; ypos_mouse = 12'd500;
    vblank(3);
    dpix(512, 384, 1'b0, 1, "t6b_still_centre");
    dpix(700, 500, 1'b0, 0, "t6b_not_latched");
    vblank(3);
    dpix(700, 500, 1'b0, 1, "t6b_next_edge");
    dpix(512, 384, 1'b0, 0, "t6b_centre_gone");

    // Random frames around a random cursor, including clamped positions
    for (int f = 0; f < 8; f++) begin
      xpos_mouse = 12'($urandom_range(0, 1300));
      ypos_mouse = 12'($urandom_range(0, 1000));
      mouse_left = 1'($urandom_range(0, 1));
      vblank(3);
      for (int i = 0; i < 300; i++) begin
        int h = m_cx + $urandom_range(0, 24) - 12;
        int v = m_cy + $urandom_range(0, 24) - 12;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        if (($urandom_range(0, 19)) == 0) xpos_mouse = 12'($urandom);
        if (($urandom_range(0, 19)) == 0) mouse_left = ~mouse_left;
        step(11'(h), 11'(v), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
             12'($urandom), "random", 1'b0, 12'h0);
      end
    end

    // Flush the last pending entry
    step(11'd0, 11'd0, 1'b1, 1'b0, 12'h0, "flush", 1'b0, 12'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
